// File: rtl/display_ctrl.sv
// display_ctrl: latches one BCD packet from N_SRC prioritised sources,
// decodes each digit to 7-segment and blanks masked digits on a blink timer.
// Ports: clk, rst (sync, active-high), src_en, bcd_in, blink_mask -> seg,
// cur_src, upd, blink_phase. Blink logic is built only when the macro
// DISPLAY_CTRL_BLINK_EN is defined; otherwise blink_phase = 0, mask ignored.
module display_ctrl #(
   parameter int N_DIGITS  = 6,
   parameter int N_SRC     = 2,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_SRC-1:0]              src_en,
   input  logic [N_SRC*N_DIGITS*4-1:0]   bcd_in,
   input  logic [N_DIGITS-1:0]           blink_mask,
   output logic [N_DIGITS*7-1:0]         seg,
   output logic [1:0]                    cur_src,
   output logic                          upd,
   output logic                          blink_phase
);

   localparam int PW = N_DIGITS * 4;

   logic [PW-1:0]       code_q, code_d;
   logic [1:0]          src_q, src_d;
   logic                upd_q, upd_d;
   logic [PW-1:0]       pkt;
   logic [1:0]          sel;
   logic                load;
   logic [N_DIGITS-1:0] blank;

   function automatic logic [6:0] dec7(input logic [3:0] c);
      logic [6:0] p;
      case (c)
         4'h0:    p = 7'b0111111;
         4'h1:    p = 7'b0000110;
         4'h2:    p = 7'b1011011;
         4'h3:    p = 7'b1001111;
         4'h4:    p = 7'b1100110;
         4'h5:    p = 7'b1101101;
         4'h6:    p = 7'b1111101;
         4'h7:    p = 7'b0000111;
         4'h8:    p = 7'b1111111;
         4'h9:    p = 7'b1101111;
         4'hA:    p = 7'b1000000;
         default: p = 7'b0000000;
      endcase
      return p;
   endfunction

   // Walk from highest index down so the lowest set index wins.
   always_comb begin
      pkt  = '0;
      sel  = '0;
      load = 1'b0;
      for (int s = N_SRC - 1; s >= 0; s--) begin
         if (src_en[s]) begin
            pkt  = bcd_in[s*PW +: PW];
            sel  = 2'(s);
            load = 1'b1;
         end
      end
   end

   always_comb begin
      code_d = load ? pkt : code_q;
      src_d  = load ? sel : src_q;
      upd_d  = load && (pkt != code_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code_q <= {N_DIGITS{4'hB}};
         src_q  <= '0;
         upd_q  <= 1'b0;
      end else begin
         code_q <= code_d;
         src_q  <= src_d;
         upd_q  <= upd_d;
      end
   end

`ifdef DISPLAY_CTRL_BLINK_EN
   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   // Restart on the changing load edge as well as while upd is high,
   // so new data is never shown blanked.
   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
      if (upd_d || upd_q) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign blink_phase = phase_q;
   assign blank       = phase_q ? blink_mask : '0;
`else
   logic unused_mask;
   assign unused_mask = ^blink_mask;
   assign blink_phase = 1'b0;
   assign blank       = '0;
`endif

   always_comb begin
      seg = '0;
      for (int d = 0; d < N_DIGITS; d++) begin
         seg[d*7 +: 7] = blank[d] ? 7'b0 : dec7(code_q[d*4 +: 4]);
      end
   end

   assign cur_src = src_q;
   assign upd     = upd_q;

endmodule

// File: tb/tb_display_ctrl.sv
// tb_display_ctrl: random and directed stimulus for display_ctrl,
// checked against a cycle-count reference model.
module tb_display_ctrl;

   localparam int ND  = 6;
   localparam int NS  = 2;
   localparam int DIV = 4;
   localparam int PW  = ND * 4;

`ifdef DISPLAY_CTRL_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NS-1:0]     src_en = '0;
   logic [NS*PW-1:0]  bcd_in = '0;
   logic [ND-1:0]     blink_mask = '0;
   logic [ND*7-1:0]   seg;
   logic [1:0]        cur_src;
   logic              upd;
   logic              blink_phase;

   display_ctrl #(.N_DIGITS(ND), .N_SRC(NS), .BLINK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .src_en(src_en), .bcd_in(bcd_in),
      .blink_mask(blink_mask), .seg(seg), .cur_src(cur_src),
      .upd(upd), .blink_phase(blink_phase)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [6:0]    tbl [16];
   logic [PW-1:0] code_m;
   int            src_m;
   bit            upd_m;
   int            since;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit ph_m();
      return BLINK_ON && (((since / DIV) % 2) == 1);
   endfunction

   function automatic logic [ND*7-1:0] seg_m();
      logic [ND*7-1:0] r;
      r = '0;
      for (int d = 0; d < ND; d++) begin
         if (!(ph_m() && blink_mask[d]))
            r[d*7 +: 7] = tbl[code_m[d*4 +: 4]];
      end
      return r;
   endfunction

   task automatic step();
      logic [NS-1:0]    en;
      logic [NS*PW-1:0] b;
      logic             r;
      logic [PW-1:0]    p;
      int               s;
      bit               chg;
      en = src_en;
      b  = bcd_in;
      r  = rst;
      @(posedge clk);
      if (r) begin
         code_m = {ND{4'hB}};
         src_m  = 0;
         upd_m  = 0;
         since  = 0;
      end else begin
         chg = 0;
         if (en != 0) begin
            s = 0;
            while (!en[s]) s++;
            p   = b[s*PW +: PW];
            chg = (p != code_m);
            code_m = p;
            src_m  = s;
         end
         if (chg || upd_m) since = 0;
         else since++;
         upd_m = chg;
      end
      #1;
      check("seg", 64'(seg), 64'(seg_m()));
      check("cur_src", 64'(cur_src), 64'(src_m));
      check("upd", 64'(upd), 64'(upd_m));
      check("phase", 64'(blink_phase), 64'(ph_m()));
   endtask

   task automatic load(input logic [NS-1:0] en, input logic [NS*PW-1:0] b);
      src_en = en;
      bcd_in = b;
      step();
      src_en = '0;
   endtask

   logic [NS*PW-1:0] last_b;

   initial begin
      tbl[0]  = 7'b0111111; tbl[1]  = 7'b0000110;
      tbl[2]  = 7'b1011011; tbl[3]  = 7'b1001111;
      tbl[4]  = 7'b1100110; tbl[5]  = 7'b1101101;
      tbl[6]  = 7'b1111101; tbl[7]  = 7'b0000111;
      tbl[8]  = 7'b1111111; tbl[9]  = 7'b1101111;
      tbl[10] = 7'b1000000;
      for (int i = 11; i < 16; i++) tbl[i] = 7'b0000000;
      code_m = '0; src_m = 0; upd_m = 0; since = 0;

      @(negedge clk);
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();
      check("rst_seg", 64'(seg), 64'd0);

      load(2'b01, {24'h0, 24'h987654});
      check("d0_4", 64'(seg[6:0]), 64'(7'b1100110));
      check("d5_9", 64'(seg[41:35]), 64'(7'b1101111));
      check("upd_pulse", 64'(upd), 64'd1);
      load(2'b01, {24'h0, 24'h987654});
      check("upd_same", 64'(upd), 64'd0);

      load(2'b11, {24'h111111, 24'hAAAAAA});
      check("prio_seg", 64'(seg), 64'({6{7'b1000000}}));
      check("prio_src", 64'(cur_src), 64'd0);
      load(2'b10, {24'h111111, 24'hAAAAAA});
      check("src1_seg", 64'(seg), 64'({6{7'b0000110}}));
      check("src1_src", 64'(cur_src), 64'd1);

      blink_mask = 6'b000001;
      load(2'b01, {24'h0, 24'h111113});
      repeat (12) step();
      for (int i = 0; i < 10 && !ph_m(); i++) step();
      load(2'b01, {24'h0, 24'h222223});
      check("restart_d0", 64'(seg[6:0]), 64'(7'b1001111));

      load(2'b01, {24'h0, 24'h11111F});
      check("codeF", 64'(seg[6:0]), 64'd0);
      blink_mask = '1;
      repeat (3) step();
      for (int i = 0; i < 10 && !ph_m(); i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_blank", 64'(seg), 64'd0);

      load(2'b10, {24'h345678, 24'h0});
      repeat (20) step();

      last_b = '0;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) == 0) blink_mask = ND'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            src_en = NS'($urandom_range(1, (1 << NS) - 1));
            if ($urandom_range(0, 1) == 0) begin
               for (int n = 0; n < NS * ND; n++)
                  bcd_in[n*4 +: 4] = 4'($urandom_range(0, 15));
               last_b = bcd_in;
            end else begin
               bcd_in = last_b;
            end
         end else begin
            src_en = '0;
         end
         step();
      end
      rst = 1'b0;
      src_en = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
